// File: rtl/axis_fifo_wr_ctrl.sv
// axis_fifo_wr_ctrl
// Write-side front end of the AXI-Stream async FIFO (write clock domain).
// AXIS beats enter a 2-entry skid buffer (head, spare). The head is written
// into the FIFO whenever the pointer handler is not full. Because of the skid
// buffer, s_axis_tready is a pure register with no combinational path from full.
//
// Ports:
//   wclk, wrst_n     write clock, asynchronous active-low reset
//   s_axis_*         AXI-Stream slave (tvalid/tready/tdata/tlast)
//   full, usedw      status from the write-pointer handler
//   w_en, w_data     write strobe and {tlast, tdata} to pointer handler / RAM
//   almost_full      registered (usedw + buffered beats) >= AFULL_THRESH
//   pkt_cnt          completed packets written (tlast beats); tied to 0 unless
//                    the macro AXIS_WR_PKTCNT_EN is defined
module axis_fifo_wr_ctrl #(
  parameter int DATA_WIDTH   = 64,
  parameter int PTR_WIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  full,
  input  logic [PTR_WIDTH:0]    usedw,
  output logic                  w_en,
  output logic [DATA_WIDTH:0]   w_data,
  output logic                  almost_full,
  output logic [15:0]           pkt_cnt
);

  localparam int EW = DATA_WIDTH + 1;
  localparam logic [PTR_WIDTH+1:0] AFULL_LVL = (PTR_WIDTH+2)'(AFULL_THRESH);

  logic [EW-1:0]        head_q, head_d;
  logic [EW-1:0]        spare_q, spare_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 tready_q, tready_d;
  logic                 afull_q, afull_d;
  logic                 acc;
  logic [EW-1:0]        beat_in;
  logic [PTR_WIDTH+1:0] level;

  assign beat_in = {s_axis_tlast, s_axis_tdata};
  assign acc     = s_axis_tvalid & tready_q;
  assign w_en    = (cnt_q != 2'd0) & ~full;
  assign w_data  = head_q;

  always_comb begin
    head_d  = head_q;
    spare_d = spare_q;
    cnt_d   = cnt_q;
    case ({acc, w_en})
      2'b01: begin
        // Drain only: spare (if any) moves up to head.
        head_d = spare_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) head_d  = beat_in;
        else               spare_d = beat_in;
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        // Accept needs cnt<2 and drain needs cnt>0, so cnt is 1 here:
        // the new beat replaces the head being written.
        head_d = beat_in;
      end
      default: ;
    endcase
    tready_d = (cnt_d < 2'd2);
    level    = {1'b0, usedw} + {{PTR_WIDTH{1'b0}}, cnt_d};
    afull_d  = (level >= AFULL_LVL);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      head_q   <= '0;
      spare_q  <= '0;
      cnt_q    <= 2'd0;
      tready_q <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      spare_q  <= spare_d;
      cnt_q    <= cnt_d;
      tready_q <= tready_d;
      afull_q  <= afull_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign almost_full   = afull_q;

`ifdef AXIS_WR_PKTCNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  // Wraps 0xFFFF -> 0x0000 naturally; only reset clears it.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q + {15'd0, (w_en & head_q[DATA_WIDTH])};
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) pkt_cnt_q <= 16'd0;
    else         pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_axis_fifo_wr_ctrl.sv
// Self-checking bench for axis_fifo_wr_ctrl: an independent occupancy model
// predicts tready / w_en / almost_full / pkt_cnt each cycle, and a scoreboard
// queue holds accepted beats until they are written.
module tb_axis_fifo_wr_ctrl;
  localparam int DW = 64;
  localparam int PW = 3;
  localparam int TH = 6;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tlast;
  logic          full;
  logic [PW:0]   usedw;
  logic          w_en;
  logic [DW:0]   w_data;
  logic          almost_full;
  logic [15:0]   pkt_cnt;

  always #5 wclk = ~wclk;

  axis_fifo_wr_ctrl #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .AFULL_THRESH(TH)) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .full(full), .usedw(usedw),
    .w_en(w_en), .w_data(w_data),
    .almost_full(almost_full), .pkt_cnt(pkt_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [DW:0] sb[$];
  int          m_cnt = 0;
  bit          m_rdy = 0;
  bit          m_af  = 0;
  logic [15:0] m_pkt = 16'd0;

  function automatic logic [15:0] exp_pkt(input logic [15:0] v);
`ifdef AXIS_WR_PKTCNT_EN
    return v;
`else
    return 16'd0;
`endif
  endfunction

  // Inputs change only #1 after posedge, so at negedge they hold the values
  // the next posedge will see.
  always @(negedge wclk) begin
    logic [DW:0] e;
    bit ew;
    bit acc;
    if (!wrst_n) begin
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_w_en", w_en, 0);
      chk("rst_afull", almost_full, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      sb.delete();
      m_cnt = 0; m_rdy = 0; m_af = 0; m_pkt = 16'd0;
    end else begin
      chk("tready", s_axis_tready, m_rdy);
      chk("almost_full", almost_full, m_af);
      chk("pkt_cnt", pkt_cnt, exp_pkt(m_pkt));
      ew = (m_cnt != 0) && !full;
      chk("w_en", w_en, ew);
      if (ew) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("w_data", w_data, e);
          if (e[DW]) m_pkt = m_pkt + 16'd1;
        end
      end
      acc = s_axis_tvalid && m_rdy;
      if (acc) sb.push_back({s_axis_tlast, s_axis_tdata});
      m_cnt = m_cnt + int'(acc) - int'(ew);
      m_rdy = (m_cnt < 2);
      m_af  = (int'(usedw) + m_cnt) >= TH;
    end
  end

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    bit r;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    for (int i = 0; i < 64; i++) begin
      r = s_axis_tready;
      step();
      if (r) begin
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    s_axis_tvalid = 1'b0;
    chk("send_timeout", 1, 0);
  endtask

  initial begin
    wrst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    full = 1'b0; usedw = '0;
    repeat (3) step();
    chk("reset_tready", s_axis_tready, 0);
    chk("reset_w_en", w_en, 0);
    chk("reset_afull", almost_full, 0);
    chk("reset_pkt_cnt", pkt_cnt, 0);

    wrst_n = 1'b1;
    step();
    chk("ready_after_release", s_axis_tready, 1);

    // Single beat, one-cycle latency to w_en.
    send(64'hA5, 1'b1);
    chk("single_w_en", w_en, 1);
    chk("single_w_data", w_data, {1'b1, 64'hA5});
    step();
    chk("single_pkt_cnt", pkt_cnt, exp_pkt(16'd1));

    // Back-to-back stream of 8 beats.
    for (int i = 0; i < 8; i++) begin
      send(DW'(i), (i == 7));
      chk("stream_tready", s_axis_tready, 1);
    end
    repeat (3) step();

    // Backpressure: full held high absorbs exactly two beats.
    full = 1'b1;
    send(64'h10, 1'b0);
    send(64'h11, 1'b0);
    chk("bp_tready", s_axis_tready, 0);
    chk("bp_w_en", w_en, 0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 64'h12; s_axis_tlast = 1'b1;
    repeat (3) step();
    chk("bp_hold_tready", s_axis_tready, 0);
    full = 1'b0;
    #1;
    chk("bp_release_w_en", w_en, 1);
    chk("bp_release_w_data", w_data, {1'b0, 64'h10});
    step();
    chk("bp_ready_back", s_axis_tready, 1);
    send(64'h12, 1'b1);
    repeat (4) step();

    // Almost full: usedw 4 + two buffered beats reaches threshold 6.
    full = 1'b1; usedw = 4'd4;
    send(64'h20, 1'b0);
    send(64'h21, 1'b1);
    chk("afull_set", almost_full, 1);
    full = 1'b0;
    repeat (4) step();
    chk("afull_clear", almost_full, 0);
    usedw = 4'd5;
    send(64'h22, 1'b1);
    chk("afull_5_plus_1", almost_full, 1);
    repeat (3) step();
    usedw = 4'd0;
    step();

    // Reset with two beats buffered.
    full = 1'b1; usedw = 4'd4;
    send(64'h30, 1'b0);
    send(64'h31, 1'b1);
    chk("pre_rst_tready", s_axis_tready, 0);
    wrst_n = 1'b0;
    #1;
    chk("midrst_w_en", w_en, 0);
    chk("midrst_tready", s_axis_tready, 0);
    chk("midrst_afull", almost_full, 0);
    repeat (2) step();
    full = 1'b0; usedw = 4'd0;
    wrst_n = 1'b1;
    step();
    chk("post_rst_tready", s_axis_tready, 1);
    send(64'h77, 1'b1);
    chk("post_rst_w_en", w_en, 1);
    chk("post_rst_first", w_data, {1'b1, 64'h77});
    repeat (3) step();

`ifdef AXIS_WR_PKTCNT_EN
    wrst_n = 1'b0;
    step();
    wrst_n = 1'b1;
    step();
    for (int i = 0; i < 65535; i++) send(DW'(i), 1'b1);
    step();
    chk("pkt_cnt_max", pkt_cnt, 16'hFFFF);
    send(64'hFF, 1'b1);
    step();
    chk("pkt_cnt_wrap", pkt_cnt, 16'h0000);
`endif

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
